axi_lite_data_master: RTL and testbench
=======================================

// Module: axi_lite_data_master
// PURPOSE
//  Bridges the core's single-beat data-memory port (ce/write_en/addr/sel/wdata) to an AXI4-Lite master.
//  Sits directly downstream of core0 in place of the on-chip RAM and drives the SoC AXI-Lite interconnect.
//  Holds the core stalled until each transaction completes, then returns read data.
//  A bus timeout flags hung slaves.
// PARAMETERS
//  ADDR_W      32    address width, byte address
//  DATA_W      32    data width; STRB_W = DATA_W/8
//  TIMEOUT     255   max cycles waiting on any single channel handshake; 0 disables the timeout
// PORTS
//  clk             in   1        system clock, rising edge
//  rst             in   1        asynchronous, active-low reset
//  ram_ce_i        in   1        core request valid; held with all attributes until stall_o falls
//  ram_write_en_i  in   1        1 = write, 0 = read
//  ram_addr_i      in   ADDR_W   byte address
//  ram_sel_i       in   STRB_W   byte enables (write strobes)
//  ram_write_data_i in  DATA_W   write data
//  ram_read_data_o out  DATA_W   read data; valid in the cycle done_o=1, held until next read completes
//  stall_o         out  1        = ram_ce_i & ~done_o (combinational)
//  done_o          out  1        one-cycle completion pulse
//  bus_err_o       out  1        sticky; set on SLVERR/DECERR response or timeout; cleared by reset only
//  m_awaddr/awprot/awvalid out ADDR_W/3/1;  m_awready in 1
//  m_wdata/wstrb/wvalid    out DATA_W/STRB_W/1;  m_wready in 1
//  m_bresp in 2;  m_bvalid in 1;  m_bready out 1
//  m_araddr/arprot/arvalid out ADDR_W/3/1;  m_arready in 1
//  m_rdata in DATA_W;  m_rresp in 2;  m_rvalid in 1;  m_rready out 1
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all m_*valid/ready=0; done_o=0; bus_err_o=0; ram_read_data_o=0.
//  Address/data/strobe registers=0; timeout counter=0; awprot/arprot constant 3'b000.
//  FSM: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
//   IDLE: ram_ce_i=1 -> latch addr/sel/wdata.
//    write_en=1 -> WR with awvalid=wvalid=1 next cycle; else RD_ADDR with arvalid=1.
//   WR: AW and W tracked independently.
//    awvalid drops the cycle after awready=1; wvalid drops the cycle after wready=1.
//    Both handshakes may occur in one cycle, in either order, or separated.
//    Leave when both are done -> WR_RESP (bready=1).
//   WR_RESP: on bvalid -> DONE; bresp[1]=1 sets bus_err_o.
//   RD_ADDR: on arready -> RD_DATA (rready=1).
//   RD_DATA: on rvalid -> capture m_rdata into ram_read_data_o; rresp[1]=1 sets bus_err_o; -> DONE.
//    Data is captured even when the response is an error.
//   DONE: done_o=1 for exactly one cycle -> IDLE.
//    A new request is not sampled in DONE, so there is at least one idle cycle between transactions.
//  Minimum latency with zero-wait slaves: write 4 cycles ce->done, read 4 cycles.
//  Valid signals never drop before their ready (AXI rule); address/data are stable while valid.
//  Timeout: counter clears on every state change and increments while in WR/WR_RESP/RD_ADDR/RD_DATA.
//   On reaching TIMEOUT: set bus_err_o, drop all valid/ready, go to DONE.
//   Read data is left unchanged on timeout.
//  ram_ce_i falling mid-transaction is illegal. The bridge completes the bus transaction regardless,
//   so no orphaned AXI handshake ever occurs.
//  rst asserted mid-transaction aborts immediately; the interconnect must be reset together with the bridge.
//  ram_sel_i=0 on a write still issues the transaction with wstrb=0.
// STRUCTURE
//  Shared package/header axi_lite.vh: AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, FSM state encodings, AXI_PROT_DEFAULT.
//  No sub-module; a single FSM with a timeout counter.
//  Top-level swaps RAM0 for this block plus an external AXI-Lite RAM slave.
// TESTING
//  1 Zero-wait write addr=0x0000_0010, sel=4'b0011, wdata=0xDEAD_BEEF
//    -> awaddr=0x10, wstrb=0011, done_o on cycle 4, bus_err_o=0.
//  2 Read addr=0x20 with arready delayed 3 and rvalid delayed 2, rdata=0x1234_5678
//    -> stall_o=1 throughout; ram_read_data_o=0x12345678 in the done_o cycle; held afterwards.
//  3 Write with wready before awready (5-cycle gap), then reversed order, then simultaneous
//    -> exactly one AW and one W handshake each; bready only after both.
//  4 bresp=2'b10 on a write, then rresp=2'b11 on a read
//    -> bus_err_o=1 after the first and stays 1; both done_o pulses still occur.
//  5 TIMEOUT=8, slave never asserts arready
//    -> arvalid drops after 8 cycles, bus_err_o=1, done_o pulse, FSM back in IDLE.
//  6 rst driven low while in WR_RESP
//    -> all outputs at reset values immediately (async); next request after rst=1 completes normally.

Source files
------------

// File: rtl/axi_lite_data_master_pkg.sv
// Shared AXI4-Lite response codes, protection default and bridge FSM encoding
// for the core-to-AXI-Lite data master.
package axi_lite_data_master_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    // SLVERR and DECERR both carry resp[1]=1; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_lite_data_master.sv
// Bridges the core's single-beat data-memory port onto an AXI4-Lite master,
// stalling the core until each transaction completes; flags errors and hung slaves.
module axi_lite_data_master
    import axi_lite_data_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_ce_i,
    input  logic              ram_write_en_i,
    input  logic [ADDR_W-1:0] ram_addr_i,
    input  logic [STRB_W-1:0] ram_sel_i,
    input  logic [DATA_W-1:0] ram_write_data_i,
    output logic [DATA_W-1:0] ram_read_data_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [STRB_W-1:0] r_strb;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic              r_done, r_err;

    logic w_busy, w_exit, w_timeout;

    always_comb begin
        w_busy = 1'b0;
        w_exit = 1'b0;
        case (r_state)
            S_WR:      begin w_busy = 1'b1; w_exit = (~r_awvalid | m_awready) & (~r_wvalid | m_wready); end
            S_WR_RESP: begin w_busy = 1'b1; w_exit = m_bvalid;  end
            S_RD_ADDR: begin w_busy = 1'b1; w_exit = m_arready; end
            S_RD_DATA: begin w_busy = 1'b1; w_exit = m_rvalid;  end
            default:   ;
        endcase
    end

    // A handshake completing in the last allowed cycle wins over the timeout,
    // so an accepted beat is never abandoned half-way.
    assign w_timeout = (TIMEOUT != 0) && w_busy && !w_exit && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_strb    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= w_busy ? r_cnt + CNT_W'(1) : '0;
            if (w_timeout) begin
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
                r_bready  <= 1'b0;
                r_arvalid <= 1'b0;
                r_rready  <= 1'b0;
                r_err     <= 1'b1;
                r_done    <= 1'b1;
                r_cnt     <= '0;
                r_state   <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: if (ram_ce_i) begin
                        r_addr  <= ram_addr_i;
                        r_strb  <= ram_sel_i;
                        r_wdata <= ram_write_data_i;
                        r_cnt   <= '0;
                        if (ram_write_en_i) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end
                    S_WR: begin
                        if (m_awready) r_awvalid <= 1'b0;
                        if (m_wready)  r_wvalid  <= 1'b0;
                        if (w_exit) begin
                            r_bready <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= S_WR_RESP;
                        end
                    end
                    S_WR_RESP: if (w_exit) begin
                        r_bready <= 1'b0;
                        if (resp_is_err(m_bresp)) r_err <= 1'b1;
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end
                    S_RD_ADDR: if (w_exit) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RD_DATA;
                    end
                    S_RD_DATA: if (w_exit) begin
                        r_rready <= 1'b0;
                        r_rdata  <= m_rdata;
                        if (resp_is_err(m_rresp)) r_err <= 1'b1;
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ram_read_data_o = r_rdata;
    assign done_o          = r_done;
    assign stall_o         = ram_ce_i & ~r_done;
    assign bus_err_o       = r_err;
    assign m_awaddr        = r_addr;
    assign m_awprot        = AXI_PROT_DEFAULT;
    assign m_awvalid       = r_awvalid;
    assign m_wdata         = r_wdata;
    assign m_wstrb         = r_strb;
    assign m_wvalid        = r_wvalid;
    assign m_bready        = r_bready;
    assign m_araddr        = r_addr;
    assign m_arprot        = AXI_PROT_DEFAULT;
    assign m_arvalid       = r_arvalid;
    assign m_rready        = r_rready;

endmodule

// File: tb/tb_axi_lite_data_master.sv
// Bench for axi_lite_data_master: configurable-latency AXI-Lite RAM slave,
// vector table, randomized traffic against a reference model, and corner sequences.
module tb_axi_lite_data_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_ce_i = 1'b0, ram_write_en_i = 1'b0;
    logic [31:0] ram_addr_i = '0, ram_write_data_i = '0;
    logic [3:0]  ram_sel_i = '0;
    logic [31:0] ram_read_data_o;
    logic        stall_o, done_o, bus_err_o;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;

    axi_lite_data_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ram_ce_i(ram_ce_i), .ram_write_en_i(ram_write_en_i), .ram_addr_i(ram_addr_i),
        .ram_sel_i(ram_sel_i), .ram_write_data_i(ram_write_data_i),
        .ram_read_data_o(ram_read_data_o), .stall_o(stall_o), .done_o(done_o), .bus_err_o(bus_err_o),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    // Slave configuration, written by the test sequence
    int       aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit       b_hang = 0, ar_hang = 0;
    logic [1:0] bresp_v = 2'b00, rresp_v = 2'b00;

    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [31:0] mem [64];
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    bit seen_aw, seen_w;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, ar_vcyc = 0, early = 0;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] res = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[b*8 +: 8] = nw[b*8 +: 8];
        return res;
    endfunction

    // Slave ready/valid responses, updated mid-cycle
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            m_awready <= 0; m_wready <= 0; m_bvalid <= 0; m_arready <= 0; m_rvalid <= 0;
            m_bresp <= 0; m_rresp <= 0; m_rdata <= 0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
        end else begin
            if (m_awvalid) begin m_awready <= (aw_wait >= aw_dly); aw_wait <= aw_wait + 1; end
            else begin m_awready <= 0; aw_wait <= 0; end
            if (m_wvalid) begin m_wready <= (w_wait >= w_dly); w_wait <= w_wait + 1; end
            else begin m_wready <= 0; w_wait <= 0; end
            if (m_bready) begin m_bvalid <= !b_hang && (b_wait >= b_dly); m_bresp <= bresp_v; b_wait <= b_wait + 1; end
            else begin m_bvalid <= 0; b_wait <= 0; end
            if (m_arvalid) begin m_arready <= !ar_hang && (ar_wait >= ar_dly); ar_wait <= ar_wait + 1; end
            else begin m_arready <= 0; ar_wait <= 0; end
            if (m_rready) begin
                m_rvalid <= (r_wait >= r_dly); m_rdata <= mem[s_araddr[7:2]]; m_rresp <= rresp_v;
                r_wait <= r_wait + 1;
            end else begin m_rvalid <= 0; r_wait <= 0; end
        end
    end

    // Slave storage and handshake monitor
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            seen_aw <= 0; seen_w <= 0;
        end else begin
            if (m_awvalid && m_awready) begin s_awaddr <= m_awaddr; aw_hs <= aw_hs + 1; seen_aw <= 1; end
            if (m_wvalid && m_wready) begin s_wdata <= m_wdata; s_wstrb <= m_wstrb; w_hs <= w_hs + 1; seen_w <= 1; end
            if (m_bready && !(seen_aw && seen_w)) early <= early + 1;
            if (m_bvalid && m_bready) begin
                mem[s_awaddr[7:2]] <= merge_bytes(mem[s_awaddr[7:2]], s_wdata, s_wstrb);
                b_hs <= b_hs + 1; seen_aw <= 0; seen_w <= 0;
            end
            if (m_arvalid && m_arready) begin s_araddr <= m_araddr; ar_hs <= ar_hs + 1; end
            if (m_rvalid && m_rready) r_hs <= r_hs + 1;
            if (m_arvalid) ar_vcyc <= ar_vcyc + 1;
        end
    end

    int tests = 0, failed = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat, output bit stall_ok, output bit hung);
        @(negedge clk);
        ram_ce_i = 1; ram_write_en_i = we; ram_addr_i = addr; ram_sel_i = sel; ram_write_data_i = wd;
        stall_ok = 1; lat = 0; hung = 1; rd = 'x;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done_o) begin
                lat = c + 1; rd = ram_read_data_o; hung = 0;
                if (stall_o) stall_ok = 0;
                break;
            end
            if (!stall_o) stall_ok = 0;
        end
        @(negedge clk);
        ram_ce_i = 0;
    endtask

    task automatic do_vec(input string nm, input bit we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wd, input int aw, input int w, input int b, input int ar, input int r,
                          input logic [1:0] resp, input logic [31:0] exp_rd, input int exp_lat, input bit exp_err);
        logic [31:0] rd; int lat; bit st_ok, hung;
        int aw0, w0, b0, ar0, r0, e0;
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
        bresp_v = we ? resp : 2'b00; rresp_v = we ? 2'b00 : resp;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs; e0 = early;
        run_txn(we, addr, sel, wd, rd, lat, st_ok, hung);
        chk({nm, " no-hang"}, 32'(hung), 32'd0);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " rdata"}, rd, exp_rd);
        chk({nm, " bus_err"}, 32'(bus_err_o), 32'(exp_err));
        chk({nm, " stall"}, 32'(st_ok), 32'd1);
        chk({nm, " handshakes"}, {aw_hs - aw0, w_hs - w0, b_hs - b0, ar_hs - ar0, r_hs - r0} == 
            (we ? {32'd1, 32'd1, 32'd1, 32'd0, 32'd0} : {32'd0, 32'd0, 32'd0, 32'd1, 32'd1}) ? 32'd1 : 32'd0, 32'd1);
        chk({nm, " bready early"}, 32'(early - e0), 32'd0);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          aw, w, b, ar, r;
        logic [1:0]  resp;
        logic [31:0] exp_rd;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    initial begin
        vec_t vt [12];
        logic [31:0] ref_mem [64];
        logic [31:0] last_rd, rd, mask;
        bit ref_err;
        int lat, base;
        bit st_ok, hung;

        vt[0]  = '{1, 32'h10, 4'b0011, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        4, 0};
        vt[1]  = '{1, 32'h20, 4'b1111, 32'h12345678, 0, 0, 0, 0, 0, 2'b00, 32'h0,        4, 0};
        vt[2]  = '{0, 32'h20, 4'b0000, 32'h0,        0, 0, 0, 3, 2, 2'b00, 32'h12345678, 9, 0};
        vt[3]  = '{0, 32'h10, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'h0000BEEF, 4, 0};
        vt[4]  = '{1, 32'h30, 4'b1111, 32'h11111111, 5, 0, 0, 0, 0, 2'b00, 32'h0000BEEF, 9, 0};
        vt[5]  = '{1, 32'h30, 4'b1100, 32'hAABB0000, 0, 5, 0, 0, 0, 2'b00, 32'h0000BEEF, 9, 0};
        vt[6]  = '{1, 32'h30, 4'b0100, 32'h00CC0000, 2, 2, 1, 0, 0, 2'b00, 32'h0000BEEF, 7, 0};
        vt[7]  = '{1, 32'h34, 4'b0000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 2'b00, 32'h0000BEEF, 4, 0};
        vt[8]  = '{0, 32'h30, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'hAACC1111, 4, 0};
        vt[9]  = '{0, 32'h34, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'h0,        4, 0};
        vt[10] = '{1, 32'h38, 4'b1111, 32'h0BADF00D, 0, 0, 0, 0, 0, 2'b10, 32'h0,        4, 1};
        vt[11] = '{0, 32'h38, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 2'b11, 32'h0BADF00D, 4, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctrl", {26'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, done_o} | {31'd0, bus_err_o}, 32'd0);
        chk("reset rdata", ram_read_data_o, 32'd0);
        chk("reset addr", m_awaddr | m_araddr | m_wdata | {28'd0, m_wstrb}, 32'd0);
        chk("reset prot", {26'd0, m_awprot, m_arprot}, 32'd0);
        @(negedge clk) rst = 1;

        for (int i = 0; i < 12; i++)
            do_vec($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].sel, vt[i].wdata, vt[i].aw, vt[i].w,
                   vt[i].b, vt[i].ar, vt[i].r, vt[i].resp, vt[i].exp_rd, vt[i].exp_lat, vt[i].exp_err);

        // Randomized traffic in the upper region against a reference model
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        last_rd = 32'h0BADF00D;
        ref_err = 1;
        for (int n = 0; n < 40; n++) begin
            bit we; int idx, aw, w, b, ar, r; logic [3:0] sel; logic [31:0] wd; logic [1:0] resp; int elat;
            logic [31:0] erd;
            we = 1'($urandom_range(0, 1)); idx = $urandom_range(16, 63); sel = 4'($urandom);
            wd = $urandom; aw = $urandom_range(0, 4); w = $urandom_range(0, 4); b = $urandom_range(0, 4);
            ar = $urandom_range(0, 4); r = $urandom_range(0, 4);
            resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            if (we) begin
                mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                ref_mem[idx] = (ref_mem[idx] & ~mask) | (wd & mask);
                elat = ((aw > w) ? aw : w) + b + 4;
            end else begin
                last_rd = ref_mem[idx];
                elat = ar + r + 4;
            end
            erd = last_rd;
            ref_err = ref_err | resp[1];
            do_vec($sformatf("rnd%0d", n), we, 32'(idx * 4), sel, wd, aw, w, b, ar, r, resp, erd, elat, ref_err);
        end

        // Reset while waiting for the write response
        aw_dly = 0; w_dly = 0; b_dly = 0; b_hang = 1; bresp_v = 2'b00;
        @(negedge clk);
        ram_ce_i = 1; ram_write_en_i = 1; ram_addr_i = 32'h3C; ram_sel_i = 4'hF; ram_write_data_i = 32'hCAFEF00D;
        base = 0;
        for (int c = 0; c < 20 && !m_bready; c++) begin @(posedge clk); #1; base = c + 1; end
        chk("midrst reached WR_RESP", 32'(m_bready), 32'd1);
        #2 rst = 0;
        #1;
        chk("midrst ctrl", {26'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, done_o}, 32'd0);
        chk("midrst err", 32'(bus_err_o), 32'd0);
        chk("midrst rdata", ram_read_data_o, 32'd0);
        ram_ce_i = 0;
        b_hang = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        do_vec("post-rst wr", 1, 32'h3C, 4'hF, 32'hCAFEF00D, 0, 0, 0, 0, 0, 2'b00, 32'h0, 4, 0);
        do_vec("post-rst rd", 0, 32'h3C, 4'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFEF00D, 4, 0);

        // Slave never accepts the read address: bridge must give up after 8 cycles
        ar_hang = 1; rresp_v = 2'b00;
        base = ar_vcyc;
        run_txn(0, 32'h3C, 4'h0, 32'h0, rd, lat, st_ok, hung);
        chk("timeout done seen", 32'(hung), 32'd0);
        chk("timeout latency", 32'(lat), 32'd10);
        chk("timeout arvalid cycles", 32'(ar_vcyc - base), 32'd8);
        chk("timeout err", 32'(bus_err_o), 32'd1);
        chk("timeout rdata kept", rd, 32'hCAFEF00D);
        chk("timeout arvalid low", 32'(m_arvalid), 32'd0);
        @(posedge clk); #1;
        chk("done single pulse", 32'(done_o), 32'd0);
        ar_hang = 0;
        do_vec("after timeout rd", 0, 32'h3C, 4'h0, 32'h0, 0, 0, 0, 1, 1, 2'b00, 32'hCAFEF00D, 6, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
